// File: rtl/alg_mm2s_cmd_arbiter.sv
// alg_mm2s_cmd_arbiter: round-robin MM2S command arbiter with in-order status routing; error counter built only with ALG_CMD_ARB_ERR_CNT_EN
module alg_mm2s_cmd_arbiter #(
    parameter int CMD_WIDTH       = 72,
    parameter int STS_WIDTH       = 8,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CMD_WIDTH-1:0] s0_cmd_tdata,
    input  logic                 s0_cmd_tvalid,
    output logic                 s0_cmd_tready,
    input  logic [CMD_WIDTH-1:0] s1_cmd_tdata,
    input  logic                 s1_cmd_tvalid,
    output logic                 s1_cmd_tready,
    output logic [CMD_WIDTH-1:0] m_cmd_tdata,
    output logic                 m_cmd_tvalid,
    input  logic                 m_cmd_tready,
    input  logic [STS_WIDTH-1:0] s_sts_tdata,
    input  logic                 s_sts_tvalid,
    output logic                 s_sts_tready,
    output logic [STS_WIDTH-1:0] m0_sts_tdata,
    output logic                 m0_sts_tvalid,
    input  logic                 m0_sts_tready,
    output logic [STS_WIDTH-1:0] m1_sts_tdata,
    output logic                 m1_sts_tvalid,
    input  logic                 m1_sts_tready,
    output logic [CNT_W-1:0]     outstanding,
    output logic                 sts_orphan,
    output logic [15:0]          err_cnt
);
    localparam int AW = $clog2(MAX_OUTSTANDING);
    typedef enum logic {IDLE, ISSUE} state_t;
    state_t state;
    logic rr_ptr, win, grant, empty, head, pop;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [MAX_OUTSTANDING-1:0] ids;
    assign win           = rr_ptr ? s1_cmd_tvalid : !s0_cmd_tvalid;
    assign grant         = state == IDLE && (s0_cmd_tvalid || s1_cmd_tvalid) && outstanding < CNT_W'(MAX_OUTSTANDING);
    assign s0_cmd_tready = grant && !win;
    assign s1_cmd_tready = grant && win;
    assign m_cmd_tvalid  = state == ISSUE;
    assign empty         = outstanding == '0;
    assign head          = ids[rd_ptr];
    assign m0_sts_tdata  = s_sts_tdata;
    assign m1_sts_tdata  = s_sts_tdata;
    assign m0_sts_tvalid = s_sts_tvalid && !empty && !head;
    assign m1_sts_tvalid = s_sts_tvalid && !empty && head;
    // With no command in flight the beat has no owner, so it is swallowed
    assign s_sts_tready  = empty || (head ? m1_sts_tready : m0_sts_tready);
    assign pop           = s_sts_tvalid && s_sts_tready && !empty;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            m_cmd_tdata <= '0;
            rr_ptr      <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            outstanding <= '0;
            sts_orphan  <= 1'b0;
        end else begin
            if (grant) begin
                state       <= ISSUE;
                m_cmd_tdata <= win ? s1_cmd_tdata : s0_cmd_tdata;
                rr_ptr      <= !win;
                wr_ptr      <= wr_ptr + AW'(1);
            end else if (state == ISSUE && m_cmd_tready) begin
                state <= IDLE;
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            outstanding <= outstanding + CNT_W'(grant) - CNT_W'(pop);
            if (s_sts_tvalid && empty)
                sts_orphan <= 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (grant)
            ids[wr_ptr] <= win;
`ifdef ALG_CMD_ARB_ERR_CNT_EN
    logic sts_err;
    assign sts_err = !s_sts_tdata[7] || |s_sts_tdata[6:4];
    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else if (s_sts_tvalid && s_sts_tready && sts_err && err_cnt != 16'hFFFF)
            err_cnt <= err_cnt + 16'd1;
    end
`else
    assign err_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_alg_mm2s_cmd_arbiter.sv
// tb_alg_mm2s_cmd_arbiter: randomized bench with a queue-based reference model and a decoupled scoreboard monitor
module tb_alg_mm2s_cmd_arbiter;
    localparam int MAXO = 4;
    logic clk = 0, rst = 1;
    logic [71:0] s0_cmd_tdata = '0, s1_cmd_tdata = '0, m_cmd_tdata;
    logic s0_cmd_tvalid = 0, s1_cmd_tvalid = 0, s0_cmd_tready, s1_cmd_tready;
    logic m_cmd_tvalid, m_cmd_tready = 0;
    logic [7:0] s_sts_tdata = '0, m0_sts_tdata, m1_sts_tdata;
    logic s_sts_tvalid = 0, s_sts_tready, m0_sts_tvalid, m1_sts_tvalid;
    logic m0_sts_tready = 0, m1_sts_tready = 0;
    logic [2:0] outstanding;
    logic sts_orphan;
    logic [15:0] err_cnt;

    alg_mm2s_cmd_arbiter dut (
        .clk(clk), .rst(rst),
        .s0_cmd_tdata(s0_cmd_tdata), .s0_cmd_tvalid(s0_cmd_tvalid), .s0_cmd_tready(s0_cmd_tready),
        .s1_cmd_tdata(s1_cmd_tdata), .s1_cmd_tvalid(s1_cmd_tvalid), .s1_cmd_tready(s1_cmd_tready),
        .m_cmd_tdata(m_cmd_tdata), .m_cmd_tvalid(m_cmd_tvalid), .m_cmd_tready(m_cmd_tready),
        .s_sts_tdata(s_sts_tdata), .s_sts_tvalid(s_sts_tvalid), .s_sts_tready(s_sts_tready),
        .m0_sts_tdata(m0_sts_tdata), .m0_sts_tvalid(m0_sts_tvalid), .m0_sts_tready(m0_sts_tready),
        .m1_sts_tdata(m1_sts_tdata), .m1_sts_tvalid(m1_sts_tvalid), .m1_sts_tready(m1_sts_tready),
        .outstanding(outstanding), .sts_orphan(sts_orphan), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic r0, r1, mv, v0, v1, sr, orph;
        logic [71:0] md;
        logic [2:0] out;
        logic [15:0] err;
    } exp_t;

    exp_t exp_q[$];
    logic [71:0] exp_cmd[$];
    logic [7:0] exp_sts0[$], exp_sts1[$];
    int vectors = 0, miscompares = 0;

    // Reference model state: queued requester IDs, command slot, preference
    int idq[$];
    bit mbusy = 0, morph = 0;
    logic [71:0] mdat = '0;
    int pref = 0, merr = 0;
    bit g0 = 0, g1 = 0, hs = 0;

    task automatic chk(input string n, input logic [71:0] a, input logic [71:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
        end
    endtask

    // Monitor: consumes expectations independently of the stimulus process
    always @(negedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("s0_tready", 72'(s0_cmd_tready), 72'(e.r0));
            chk("s1_tready", 72'(s1_cmd_tready), 72'(e.r1));
            chk("m_cmd_tvalid", 72'(m_cmd_tvalid), 72'(e.mv));
            chk("m_cmd_tdata", m_cmd_tdata, e.md);
            chk("outstanding", 72'(outstanding), 72'(e.out));
            chk("m0_sts_tvalid", 72'(m0_sts_tvalid), 72'(e.v0));
            chk("m1_sts_tvalid", 72'(m1_sts_tvalid), 72'(e.v1));
            chk("s_sts_tready", 72'(s_sts_tready), 72'(e.sr));
            chk("sts_orphan", 72'(sts_orphan), 72'(e.orph));
            chk("err_cnt", 72'(err_cnt), 72'(e.err));
            if (m_cmd_tvalid && m_cmd_tready)
                chk("cmd_order", m_cmd_tdata, exp_cmd.size() ? exp_cmd.pop_front() : 72'hx);
            if (m0_sts_tvalid && m0_sts_tready)
                chk("m0_sts", 72'(m0_sts_tdata), exp_sts0.size() ? 72'(exp_sts0.pop_front()) : 72'hx);
            if (m1_sts_tvalid && m1_sts_tready)
                chk("m1_sts", 72'(m1_sts_tdata), exp_sts1.size() ? 72'(exp_sts1.pop_front()) : 72'hx);
        end
    end

    task automatic model_cycle();
        exp_t e;
        bit grant, empty, sts_bad;
        int win, head;
        empty = idq.size() == 0;
        head = empty ? 0 : idq[0];
        grant = !mbusy && (s0_cmd_tvalid || s1_cmd_tvalid) && idq.size() < MAXO;
        win = (pref == 0) ? (s0_cmd_tvalid ? 0 : 1) : (s1_cmd_tvalid ? 1 : 0);
        e.r0 = grant && win == 0;
        e.r1 = grant && win == 1;
        e.mv = mbusy;
        e.md = mdat;
        e.out = 3'(idq.size());
        e.v0 = s_sts_tvalid && !empty && head == 0;
        e.v1 = s_sts_tvalid && !empty && head == 1;
        e.sr = empty ? 1'b1 : (head == 1 ? m1_sts_tready : m0_sts_tready);
        e.orph = morph;
        e.err = 16'(merr);
        exp_q.push_back(e);
        hs = s_sts_tvalid && e.sr;
        if (hs && !empty) begin
            void'(idq.pop_front());
            if (head == 0) exp_sts0.push_back(s_sts_tdata);
            else exp_sts1.push_back(s_sts_tdata);
        end
        if (s_sts_tvalid && empty) morph = 1;
        sts_bad = !s_sts_tdata[7] || s_sts_tdata[6] || s_sts_tdata[5] || s_sts_tdata[4];
`ifdef ALG_CMD_ARB_ERR_CNT_EN
        if (hs && sts_bad && merr < 65535) merr++;
`endif
        if (mbusy && m_cmd_tready) mbusy = 0;
        if (grant) begin
            mbusy = 1;
            mdat = win ? s1_cmd_tdata : s0_cmd_tdata;
            pref = 1 - win;
            idq.push_back(win);
            exp_cmd.push_back(mdat);
        end
        g0 = e.r0;
        g1 = e.r1;
    endtask

    initial begin
        logic [7:0] stsv[6];
        int preq, psts, prdy;
        stsv = '{8'h80, 8'h40, 8'h00, 8'h90, 8'hA0, 8'hC0};
        repeat (3) @(posedge clk);
        #1 rst = 0;
        for (int c = 0; c < 1600; c++) begin
            @(negedge clk);
            model_cycle();
            @(posedge clk);
            #1;
            preq = c < 1580 ? 60 : 0;
            psts = c < 40 ? 0 : c < 80 ? 80 : c < 100 ? 0 : c < 1580 ? 40 : 0;
            prdy = c < 80 ? 100 : c < 100 ? 0 : c < 1580 ? 70 : 100;
            if (g0) s0_cmd_tvalid = 0;
            if (g1) s1_cmd_tvalid = 0;
            if (!s0_cmd_tvalid && $urandom_range(0, 99) < preq) begin
                s0_cmd_tvalid = 1;
                s0_cmd_tdata = 72'({$urandom, $urandom, $urandom});
            end
            if (!s1_cmd_tvalid && $urandom_range(0, 99) < preq) begin
                s1_cmd_tvalid = 1;
                s1_cmd_tdata = 72'({$urandom, $urandom, $urandom});
            end
            if (hs) s_sts_tvalid = 0;
            if (!s_sts_tvalid && $urandom_range(0, 99) < psts) begin
                s_sts_tvalid = 1;
                s_sts_tdata = stsv[$urandom_range(0, 5)];
            end
            m_cmd_tready = $urandom_range(0, 99) < prdy;
            m0_sts_tready = $urandom_range(0, 99) < 70;
            m1_sts_tready = $urandom_range(0, 99) < 70;
        end
        @(negedge clk);
        #4;
        chk("cmd_drained", 72'(exp_cmd.size()), 72'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
